// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared constants for the 4-bit CPU program loader:
//   - OP_* opcode encodings used by the CPU fetch/decode path
//   - NOP_WORD padding word
//   - LD_* loader FSM state codes
//   - instr_t beat layout and opcode classification helpers
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    // CPU opcodes (upper nibble of an instruction word)
    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_ADD_A_IM = 4'h1;
    localparam logic [3:0] OP_ADD_B_IM = 4'h2;
    localparam logic [3:0] OP_MOV_A_IM = 4'h3;
    localparam logic [3:0] OP_MOV_B_IM = 4'h4;
    localparam logic [3:0] OP_MOV_A_B  = 4'h5;
    localparam logic [3:0] OP_MOV_B_A  = 4'h6;
    localparam logic [3:0] OP_IN_A     = 4'h7;
    localparam logic [3:0] OP_IN_B     = 4'h8;

    // Word used for padding and for replacing unsupported opcodes
    localparam logic [7:0] NOP_WORD = {OP_NOP, 4'h0};

    // Highest program-memory address (16-entry memory, 4-bit PC)
    localparam logic [3:0] LAST_ADDR = 4'hF;

    // Loader FSM state codes
    localparam logic [1:0] LD_IDLE = 2'd0;
    localparam logic [1:0] LD_LOAD = 2'd1;
    localparam logic [1:0] LD_FILL = 2'd2;
    localparam logic [1:0] LD_RUN  = 2'd3;

    // One instruction beat as it arrives on the stream
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] imm;
    } instr_t;

    // True for every opcode the CPU decodes
    function automatic logic op_supported(input logic [3:0] op);
        logic ok;
        case (op)
            OP_NOP, OP_ADD_A_IM, OP_ADD_B_IM, OP_MOV_A_IM, OP_MOV_B_IM,
            OP_MOV_A_B, OP_MOV_B_A, OP_IN_A, OP_IN_B: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for opcodes whose immediate field carries an operand
    function automatic logic op_uses_imm(input logic [3:0] op);
        logic uses;
        case (op)
            OP_ADD_A_IM, OP_ADD_B_IM, OP_MOV_A_IM, OP_MOV_B_IM: uses = 1'b1;
            default:                                            uses = 1'b0;
        endcase
        return uses;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Bundles the loader's control, instruction stream, memory write port and
// status signals.
//   master : the program source / system controller (drives start and beats)
//   slave  : prog_loader (drives in_ready, memory writes and status)
// Signals:
//   start                 load request pulse
//   in_valid/in_ready     beat handshake; in_op, in_imm, in_last beat payload
//   mem_we/addr/wdata     program-memory write port
//   cpu_hold, busy, done  CPU reset hold and loader status
//   err_bad_op, count     sticky bad-opcode flag and accepted-beat count
// -----------------------------------------------------------------------------
interface prog_loader_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [3:0] in_imm;
    logic       in_last;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err_bad_op;
    logic [4:0] count;

    modport master (
        output start, in_valid, in_op, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, busy, done, err_bad_op, count
    );

    modport slave (
        input  start, in_valid, in_op, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, busy, done, err_bad_op, count
    );
endinterface

// File: rtl/prog_loader_instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Combinational packing of one instruction beat into an 8-bit word.
//   instr  in  : {op, imm} beat
//   word   out : {op, imm} for immediate-carrying opcodes, {op, 0} for the
//                register/input/NOP opcodes, NOP_WORD for unsupported ones
//   bad_op out : the opcode was unsupported and has been replaced
// -----------------------------------------------------------------------------
module instr_encoder
    import prog_loader_pkg::*;
(
    input  instr_t     instr,
    output logic [7:0] word,
    output logic       bad_op
);

    // Validate the opcode and mask the immediate where it carries no meaning
    always_comb begin
        word   = NOP_WORD;
        bad_op = 1'b0;
        if (!op_supported(instr.op)) begin
            word   = NOP_WORD;
            bad_op = 1'b1;
        end else if (op_uses_imm(instr.op)) begin
            word   = {instr.op, instr.imm};
            bad_op = 1'b0;
        end else begin
            word   = {instr.op, 4'h0};
            bad_op = 1'b0;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Loads a program image for the 4-bit CPU into its 16-entry program memory.
// Instruction beats are accepted over a valid/ready handshake, packed into
// 8-bit words and written in address order; any addresses the program does
// not reach are padded with NOP_WORD. The CPU is held in reset until the whole
// image is written.
// Ports:
//   clk  in : system clock, rising edge
//   rst  in : asynchronous active-high reset
//   bus     : prog_loader_if.slave (start, beat stream, memory write port,
//             cpu_hold/busy/done/err_bad_op/count status)
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [3:0] wr_addr_r;      // next address to be written
    logic [4:0] count_r;
    logic       err_r;
    logic       mem_we_r;
    logic [3:0] mem_addr_r;
    logic [7:0] mem_wdata_r;
    logic       in_ready_r;
    logic       busy_r;
    logic       done_r;
    logic       cpu_hold_r;
    logic       accept_s;
    logic       run_stay_s;
    instr_t     beat_s;
    logic [7:0] enc_word_s;
    logic       enc_bad_s;

    assign beat_s.op  = bus.in_op;
    assign beat_s.imm = bus.in_imm;

    instr_encoder u_encoder (
        .instr  (beat_s),
        .word   (enc_word_s),
        .bad_op (enc_bad_s)
    );

    // in_ready_r mirrors "state is LOAD", so this has no path back from in_valid
    assign accept_s = bus.in_valid && in_ready_r;

    // Staying in RUN for another cycle; done/cpu_hold follow this one cycle
    // later so they only move after the final write strobe has been seen
    assign run_stay_s = (state_r == LD_RUN) && (state_nxt_s == LD_RUN);

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LD_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = LD_LOAD;
                end else begin
                    state_nxt_s = LD_IDLE;
                end
            end
            LD_LOAD: begin
                if (accept_s) begin
                    if (wr_addr_r == LAST_ADDR) begin
                        state_nxt_s = LD_RUN;
                    end else if (bus.in_last) begin
                        state_nxt_s = LD_FILL;
                    end else begin
                        state_nxt_s = LD_LOAD;
                    end
                end else begin
                    state_nxt_s = LD_LOAD;
                end
            end
            LD_FILL: begin
                if (wr_addr_r == LAST_ADDR) begin
                    state_nxt_s = LD_RUN;
                end else begin
                    state_nxt_s = LD_FILL;
                end
            end
            LD_RUN: begin
                if (bus.start) begin
                    state_nxt_s = LD_LOAD;
                end else begin
                    state_nxt_s = LD_RUN;
                end
            end
            default: begin
                state_nxt_s = LD_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LD_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered status outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cpu_hold_r <= 1'b1;
        end else begin
            in_ready_r <= (state_nxt_s == LD_LOAD);
            busy_r     <= (state_nxt_s == LD_LOAD) || (state_nxt_s == LD_FILL);
            done_r     <= run_stay_s;
            cpu_hold_r <= !run_stay_s;
        end
    end

    // Write address, beat count and sticky bad-opcode flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_r <= 4'h0;
            count_r   <= 5'd0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                LD_IDLE, LD_RUN: begin
                    if (bus.start) begin
                        wr_addr_r <= 4'h0;
                        count_r   <= 5'd0;
                        err_r     <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (accept_s) begin
                        count_r <= count_r + 5'd1;
                        if (enc_bad_s) begin
                            err_r <= 1'b1;
                        end
                        // Saturate at the last address: never wrap onto word 0
                        if (wr_addr_r != LAST_ADDR) begin
                            wr_addr_r <= wr_addr_r + 4'd1;
                        end
                    end
                end
                LD_FILL: begin
                    if (wr_addr_r != LAST_ADDR) begin
                        wr_addr_r <= wr_addr_r + 4'd1;
                    end
                end
                default: begin
                    wr_addr_r <= wr_addr_r;
                end
            endcase
        end
    end

    // Program-memory write port; the strobe is a single-cycle pulse per word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 4'h0;
            mem_wdata_r <= 8'h00;
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                LD_LOAD: begin
                    if (accept_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= wr_addr_r;
                        mem_wdata_r <= enc_word_s;
                    end
                end
                LD_FILL: begin
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= wr_addr_r;
                    mem_wdata_r <= NOP_WORD;
                end
                default: begin
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.cpu_hold   = cpu_hold_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err_bad_op = err_r;
    assign bus.count      = count_r;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Each load's expected write sequence is
// derived from the program description and pushed into a queue; a monitor on
// the falling clock edge pops and compares every memory write.
// -----------------------------------------------------------------------------
module tb_prog_loader;
    import prog_loader_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    wr_t  exp_q[$];

    logic [3:0] b_op   [16];
    logic [3:0] b_imm  [16];
    logic       b_last [16];

    prog_loader_if bus();

    prog_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference encoding straight from the instruction-set rules
    function automatic bit is_supported(input logic [3:0] op);
        return op inside {OP_NOP, OP_ADD_A_IM, OP_ADD_B_IM, OP_MOV_A_IM, OP_MOV_B_IM,
                          OP_MOV_A_B, OP_MOV_B_A, OP_IN_A, OP_IN_B};
    endfunction

    function automatic logic [7:0] model_word(input logic [3:0] op, input logic [3:0] imm);
        if (!is_supported(op)) return 8'h00;
        if (op inside {OP_ADD_A_IM, OP_ADD_B_IM, OP_MOV_A_IM, OP_MOV_B_IM}) return {op, imm};
        return {op, 4'h0};
    endfunction

    // Monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (!rst) begin
            check("hold_vs_done", bus.cpu_hold, !bus.done);
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h (cycle %0d)",
                             bus.mem_addr, bus.mem_wdata, cyc);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_addr, e.a);
                    check("wr_data", bus.mem_wdata, e.d);
                end
            end
        end
    end

    // Present one beat starting at a falling edge; returns one falling edge
    // after the cycle in which it was accepted
    task automatic drive_beat(input logic [3:0] op, input logic [3:0] imm,
                              input logic last, output int acc_cyc);
        int tries;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_imm   = imm;
        bus.in_last  = last;
        tries = 0;
        while (!bus.in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) fail_now("in_ready_timeout");
        acc_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic set_prog(input int n, input bit any_op);
        for (int i = 0; i < 16; i++) begin
            b_op[i]   = any_op ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            b_imm[i]  = 4'($urandom_range(0, 15));
            b_last[i] = 1'b0;
        end
        if (n < 16) b_last[n-1] = 1'b1;
        else        b_last[15]  = 1'($urandom_range(0, 1));
    endtask

    // One complete load: model, start, beats, fill, completion checks
    task automatic do_load(input bit gaps, input bit noise);
        int  n_acc;
        bit  exp_bad;
        int  acc;
        int  tries;
        n_acc   = 0;
        exp_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_acc = i + 1;
            if (!is_supported(b_op[i])) exp_bad = 1'b1;
            exp_q.push_back('{a: 4'(i), d: model_word(b_op[i], b_imm[i])});
            if (b_last[i]) break;
        end
        for (int a = n_acc; a < 16; a++) exp_q.push_back('{a: 4'(a), d: 8'h00});

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_hold", bus.cpu_hold, 1'b1);
        check("start_done", bus.done, 1'b0);
        check("start_count", bus.count, 5'd0);
        check("start_err", bus.err_bad_op, 1'b0);
        check("start_ready", bus.in_ready, 1'b1);
        check("start_busy", bus.busy, 1'b1);

        for (int i = 0; i < n_acc; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_op    = 4'($urandom_range(0, 15));
                bus.start    = 1'($urandom_range(0, 1));
                @(negedge clk);
                bus.start = 1'b0;
            end
            drive_beat(b_op[i], b_imm[i], b_last[i], acc);
        end

        bus.in_valid = noise;
        bus.in_op    = 4'($urandom_range(0, 15));
        bus.in_last  = 1'($urandom_range(0, 1));
        if (gaps && n_acc < 16) bus.start = 1'b1;
        tries = 0;
        while (!bus.done && tries < 40) begin
            @(negedge clk);
            bus.start = 1'b0;
            tries++;
        end
        bus.start = 1'b0;
        if (tries >= 40) begin
            fail_now("done_timeout");
        end else begin
            check("done_cycle", cyc, acc + 18 - n_acc);
            check("writes_before_done", exp_q.size(), 0);
            check("run_count", bus.count, n_acc);
            check("run_err", bus.err_bad_op, exp_bad);
            check("run_hold", bus.cpu_hold, 1'b0);
            check("run_busy", bus.busy, 1'b0);
            check("run_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        check("run_count_stable", bus.count, n_acc);
        check("run_done_stable", bus.done, 1'b1);
        exp_q.delete();
    endtask

    task automatic fixed_three();
        set_prog(3, 1'b0);
        b_op[0] = OP_MOV_A_IM; b_imm[0] = 4'd3;
        b_op[1] = OP_ADD_A_IM; b_imm[1] = 4'd1;
        b_op[2] = OP_MOV_B_A;  b_imm[2] = 4'd7;
    endtask

    initial begin
        int acc;
        cyc = 0; tests = 0; fails = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_op = 4'h0;
        bus.in_imm = 4'h0; bus.in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold", bus.cpu_hold, 1'b1);
        check("rst_ready", bus.in_ready, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err_bad_op, 1'b0);
        check("rst_addr", bus.mem_addr, 4'h0);
        check("rst_wdata", bus.mem_wdata, 8'h00);
        check("rst_count", bus.count, 5'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_hold", bus.cpu_hold, 1'b1);

        // Three-beat program with padding
        fixed_three();
        do_load(1'b0, 1'b0);
        // Reload from RUN with the same image
        do_load(1'b0, 1'b0);
        // Sixteen beats, no in_last, in_valid held high afterwards
        set_prog(16, 1'b0);
        b_last[15] = 1'b0;
        do_load(1'b0, 1'b1);
        // Unsupported opcode at address 1
        set_prog(3, 1'b0);
        b_op[1] = 4'hB; b_imm[1] = 4'd5;
        do_load(1'b0, 1'b0);
        // Gapped valid and stray start pulses (next start also clears err)
        set_prog(7, 1'b0);
        do_load(1'b1, 1'b0);

        // Reset after the 4th beat
        set_prog(8, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back('{a: 4'(i), d: model_word(b_op[i], b_imm[i])});
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) drive_beat(b_op[i], b_imm[i], 1'b0, acc);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_hold", bus.cpu_hold, 1'b1);
        check("abort_done", bus.done, 1'b0);
        check("abort_count", bus.count, 5'd0);
        check("abort_ready", bus.in_ready, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_writes", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        fixed_three();
        do_load(1'b0, 1'b0);

        // Randomised loads
        for (int r = 0; r < 8; r++) begin
            set_prog($urandom_range(1, 16), 1'b1);
            do_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
